mkio_tx_encoder: RTL and testbench
==================================

MKIO_TX_ENCODER -- requirements
Module: mkio_tx_encoder

Interface
REQ-001 Parameter HALF_BIT_CLKS, default 25, clk cycles per Manchester half-bit (25 at 50 MHz gives 1 Mbit/s); legal range 2..255.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tx_data  input  16  word to transmit; sampled on a request.
REQ-005 tx_cd  input  1  sync select, sampled with tx_data: 0 = command/status sync, 1 = data sync.
REQ-006 tx_ready  input  1  transmit request, level signal; a 0->1 transition is a request.
REQ-007 tx_busy  output  1  high while a word is on the line or pending.
REQ-008 tx_p  output  1  line drive, positive phase.
REQ-009 tx_n  output  1  line drive, negative phase.
REQ-010 tx_en  output  1  line driver enable.
REQ-011 tx_ovf  output  1  one-cycle pulse when a request is dropped.

Function
REQ-012 A request SHALL be detected on the cycle where tx_ready=1 and its registered previous value=0; a held-high tx_ready SHALL NOT re-trigger.
REQ-013 FSM states SHALL be IDLE, SYNC, DATA, PARITY.
- IDLE -> SYNC on a request; tx_data and tx_cd are latched on the detection cycle.
- SYNC -> DATA after 6 half-bits.
- DATA -> PARITY after 32 half-bits.
- PARITY -> SYNC if the pending slot is full, else -> IDLE, after 2 half-bits.
REQ-014 A half-bit counter SHALL count HALF_BIT_CLKS cycles; a half-bit index SHALL step 0..39 per word.
REQ-015 Sync for tx_cd=0 SHALL be tx_p high for 3 half-bits, then low for 3 half-bits; tx_cd=1 SHALL be the inverse.
REQ-016 Data SHALL be sent MSB first (bit 15 first); bit value 1 = high then low, 0 = low then high.
REQ-017 The parity bit SHALL be odd parity over the 16 data bits (the XNOR-reduction of tx_data), encoded as in REQ-016.
REQ-018 While tx_en=1, tx_n SHALL equal ~tx_p; while tx_en=0, tx_p=tx_n=0.
REQ-019 Latency: the first sync half-bit SHALL appear on tx_p/tx_en on the cycle after request detection.
REQ-020 A word SHALL occupy exactly 40*HALF_BIT_CLKS cycles.
REQ-021 tx_busy SHALL rise together with tx_en.
REQ-022 tx_busy SHALL fall on the cycle after the last parity half-bit when no word is pending.
REQ-023 One-word pending slot: a request while busy with the slot empty SHALL store tx_data/tx_cd.
REQ-024 The pending word SHALL start on the cycle immediately after the current parity ends: no dead cycle, and tx_en and tx_busy stay high.
REQ-025 A request while busy with the slot full SHALL be dropped; tx_ovf SHALL pulse one cycle; the current and pending words are unaffected.
REQ-026 A request on the final cycle of a word with the slot empty SHALL be treated as pending and follow REQ-024.
REQ-027 tx_data/tx_cd changes outside a request cycle SHALL NOT affect a word in flight.

Reset
REQ-028 While reset=1, registers SHALL be set as follows:
- FSM = IDLE; counters = 0; pending slot empty.
- previous-tx_ready register = 1, so a tx_ready already high at release does not trigger.
- tx_busy=0, tx_p=0, tx_n=0, tx_en=0, tx_ovf=0.
REQ-029 Reset mid-word SHALL force the line idle on the next edge; the partial word and the pending word are discarded without completion.

Verification (HALF_BIT_CLKS=2)
REQ-030 Status word: tx_data=16'h0800, tx_cd=0, tx_ready pulsed -> tx_p = 6 cycles high, 6 low, then the Manchester pattern of 0000_1000_0000_0000; parity bit 0 (low-high); tx_busy high exactly 80 cycles.
REQ-031 Data word: tx_data=16'hFFFF, tx_cd=1 -> tx_p = 6 low, 6 high, then 16 x (high,high,low,low); parity 1; tx_n = ~tx_p throughout; tx_en=0 afterwards.
REQ-032 Back-to-back: request 16'hA5A5 (cd=0), then 16'h1234 (cd=1) 10 cycles later -> second sync starts on cycle 81 with no gap; tx_busy high 160 cycles continuously.
REQ-033 Overflow: three requests within 30 cycles -> third dropped, tx_ovf single-cycle pulse, exactly two words transmitted.
REQ-034 tx_ready held high 200 cycles -> exactly one word sent.
REQ-035 Reset asserted at cycle 37 of a word while a word is pending -> next cycle tx_en=tx_p=tx_n=tx_busy=0; after release there is no transmission without a new 0->1 on tx_ready.

Source files
------------

// File: rtl/mkio_tx_encoder.sv
// mkio_tx_encoder -- MIL-STD-1553 style Manchester-II word transmitter.
//
// A word is 40 half-bits: 6 sync half-bits, 16 data bits sent MSB first
// (1 = high/low, 0 = low/high), then one odd-parity bit. A one-word pending
// slot allows back-to-back transmission with no gap between words.
//
// Ports:
//   clk       - single clock, all logic on rising edge
//   reset     - synchronous, active-high
//   tx_data   - 16-bit word, sampled on a request
//   tx_cd     - sync select (0 = command/status, 1 = data), sampled with tx_data
//   tx_ready  - transmit request level; a 0->1 transition is a request
//   tx_busy   - high while a word is on the line or pending
//   tx_p      - line drive, positive phase
//   tx_n      - line drive, negative phase (~tx_p while enabled)
//   tx_en     - line driver enable
//   tx_ovf    - one-cycle pulse when a request is dropped (slot full)
module mkio_tx_encoder #(
  parameter int unsigned HALF_BIT_CLKS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        tx_ovf
);

  localparam logic [7:0] HB_LAST  = 8'(HALF_BIT_CLKS - 1);
  localparam logic [5:0] IDX_LAST = 6'd39;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hb_cnt_q, hb_cnt_d;
  logic [5:0]  hb_idx_q, hb_idx_d;
  logic [15:0] word_q, word_d;
  logic        cd_q, cd_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        pend_cd_q, pend_cd_d;
  logic        rdy_prev_q;

  logic        req;
  logic        active;
  logic        hb_end;
  logic        word_end;
  logic        run_d;
  logic        ovf_d;
  logic        line_bit;

  // Line level for a given half-bit index of a word.
  function automatic logic line_value(input logic [5:0]  idx,
                                      input logic [15:0] w,
                                      input logic        cd);
    logic [5:0] k;
    logic [3:0] bsel;
    k    = '0;
    bsel = '0;
    if (idx < 6'd6) begin
      return (idx < 6'd3) ^ cd;
    end else if (idx < 6'd38) begin
      k    = idx - 6'd6;
      bsel = 4'd15 - k[4:1];
      return w[bsel] ^ k[0];
    end else begin
      return (~^w) ^ idx[0];
    end
  endfunction

  always_comb begin
    req      = tx_ready & ~rdy_prev_q;
    active   = (state_q != IDLE);
    hb_end   = (hb_cnt_q == HB_LAST);
    word_end = hb_end && (hb_idx_q == IDX_LAST);

    hb_cnt_d    = hb_cnt_q;
    hb_idx_d    = hb_idx_q;
    word_d      = word_q;
    cd_d        = cd_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_cd_d   = pend_cd_q;
    run_d       = active;
    ovf_d       = 1'b0;

    if (!active) begin
      if (req) begin
        run_d    = 1'b1;
        hb_cnt_d = '0;
        hb_idx_d = '0;
        word_d   = tx_data;
        cd_d     = tx_cd;
      end
    end else begin
      if (hb_end) begin
        hb_cnt_d = '0;
        hb_idx_d = hb_idx_q + 6'd1;
      end else begin
        hb_cnt_d = hb_cnt_q + 8'd1;
      end

      if (word_end) begin
        hb_idx_d = '0;
        if (pend_vld_q) begin
          word_d     = pend_data_q;
          cd_d       = pend_cd_q;
          pend_vld_d = 1'b0;
          ovf_d      = req;
        end else if (req) begin
          // A request on the last cycle of a word with an empty slot goes
          // straight to the line, exactly as if it had been pending.
          word_d = tx_data;
          cd_d   = tx_cd;
        end else begin
          run_d = 1'b0;
        end
      end else if (req) begin
        if (pend_vld_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_data_d = tx_data;
          pend_cd_d   = tx_cd;
        end
      end
    end

    if (!run_d) begin
      state_d = IDLE;
    end else if (hb_idx_d < 6'd6) begin
      state_d = SYNC;
    end else if (hb_idx_d < 6'd38) begin
      state_d = DATA;
    end else begin
      state_d = PARITY;
    end

    // Encoded from next-cycle values so the line output is registered yet
    // shows the first sync half-bit on the cycle after request detection.
    line_bit = line_value(hb_idx_d, word_d, cd_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hb_cnt_q    <= '0;
      hb_idx_q    <= '0;
      word_q      <= '0;
      cd_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_cd_q   <= 1'b0;
      rdy_prev_q  <= 1'b1;
      tx_busy     <= 1'b0;
      tx_en       <= 1'b0;
      tx_p        <= 1'b0;
      tx_n        <= 1'b0;
      tx_ovf      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_idx_q    <= hb_idx_d;
      word_q      <= word_d;
      cd_q        <= cd_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_cd_q   <= pend_cd_d;
      rdy_prev_q  <= tx_ready;
      tx_busy     <= run_d;
      tx_en       <= run_d;
      tx_p        <= run_d & line_bit;
      tx_n        <= run_d & ~line_bit;
      tx_ovf      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mkio_tx_encoder.sv
// Testbench for mkio_tx_encoder: directed scenarios plus randomized traffic,
// every cycle compared against a half-bit queue reference model.
module tb_mkio_tx_encoder;

  localparam int unsigned HBC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy, tx_p, tx_n, tx_en, tx_ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: queue of expected tx_p levels, one entry per clk cycle.
  bit          line_q[$];
  bit          pend_v;
  logic [15:0] pend_d;
  bit          pend_c;
  bit          prev_rdy;
  bit          exp_ovf;

  int unsigned busy_cycles;
  int unsigned ovf_pulses;

  mkio_tx_encoder #(.HALF_BIT_CLKS(HBC)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_cd    (tx_cd),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_p     (tx_p),
    .tx_n     (tx_n),
    .tx_en    (tx_en),
    .tx_ovf   (tx_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  function automatic void push_half(input bit v);
    for (int c = 0; c < HBC; c++) line_q.push_back(v);
  endfunction

  function automatic void push_word(input logic [15:0] d, input bit cd);
    bit par;
    par = ~^d;
    for (int h = 0; h < 3; h++) push_half(~cd);
    for (int h = 0; h < 3; h++) push_half(cd);
    for (int i = 15; i >= 0; i--) begin
      push_half(d[i]);
      push_half(~d[i]);
    end
    push_half(par);
    push_half(~par);
  endfunction

  function automatic void model_edge();
    bit          req;
    int unsigned sz;
    exp_ovf = 1'b0;
    if (reset) begin
      line_q.delete();
      pend_v   = 1'b0;
      prev_rdy = 1'b1;
      return;
    end
    req      = tx_ready && !prev_rdy;
    prev_rdy = tx_ready;
    sz       = line_q.size();
    if (sz > 0) void'(line_q.pop_front());
    if (req) begin
      if (sz == 0 || (sz == 1 && !pend_v)) begin
        push_word(tx_data, tx_cd);
      end else if (!pend_v) begin
        pend_v = 1'b1;
        pend_d = tx_data;
        pend_c = tx_cd;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (line_q.size() == 0 && pend_v) begin
      push_word(pend_d, pend_c);
      pend_v = 1'b0;
    end
  endfunction

  task automatic step();
    logic [4:0] exp_v;
    bit         en;
    bit         lv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    en    = (line_q.size() > 0);
    lv    = en ? line_q[0] : 1'b0;
    exp_v = {en, en, en & lv, en & ~lv, exp_ovf};
    check("busy_en_p_n_ovf", {27'd0, tx_busy, tx_en, tx_p, tx_n, tx_ovf}, {27'd0, exp_v});
    if (tx_busy) busy_cycles++;
    if (tx_ovf)  ovf_pulses++;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Request, then scramble data/cd so a word in flight must not follow them.
  task automatic pulse_req(input logic [15:0] d, input bit cd);
    tx_data  = d;
    tx_cd    = cd;
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    tx_data  = 16'($urandom);
    tx_cd    = 1'($urandom);
    step();
  endtask

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    tx_data  = '0;
    tx_cd    = 1'b0;
    step();
    step();
    check("reset_state", {27'd0, tx_busy, tx_en, tx_p, tx_n, tx_ovf}, 32'd0);
    reset = 1'b0;
    step();

    // Status word, command sync
    busy_cycles = 0;
    pulse_req(16'h0800, 1'b0);
    idle_cycles(100);
    check("status_busy_cycles", busy_cycles, 32'd80);

    // Data word, data sync
    busy_cycles = 0;
    pulse_req(16'hFFFF, 1'b1);
    idle_cycles(100);
    check("data_busy_cycles", busy_cycles, 32'd80);
    check("data_en_after", {31'd0, tx_en}, 32'd0);

    // Back-to-back through the pending slot
    busy_cycles = 0;
    pulse_req(16'hA5A5, 1'b0);
    idle_cycles(8);
    pulse_req(16'h1234, 1'b1);
    idle_cycles(200);
    check("b2b_busy_cycles", busy_cycles, 32'd160);

    // Overflow: third request dropped
    busy_cycles = 0;
    ovf_pulses  = 0;
    pulse_req(16'h0F0F, 1'b0);
    idle_cycles(8);
    pulse_req(16'hC3C3, 1'b1);
    idle_cycles(8);
    pulse_req(16'h5555, 1'b0);
    idle_cycles(200);
    check("ovf_busy_cycles", busy_cycles, 32'd160);
    check("ovf_pulses", ovf_pulses, 32'd1);

    // Held-high tx_ready sends one word
    busy_cycles = 0;
    tx_data  = 16'h8001;
    tx_cd    = 1'b1;
    tx_ready = 1'b1;
    idle_cycles(200);
    tx_ready = 1'b0;
    idle_cycles(20);
    check("held_ready_busy_cycles", busy_cycles, 32'd80);

    // Request landing on the final cycle of a word, then one cycle earlier
    for (int unsigned gap = 78; gap >= 77; gap--) begin
      busy_cycles = 0;
      pulse_req(16'h7E81, 1'b0);
      idle_cycles(gap);
      pulse_req(16'h3C5A, 1'b1);
      idle_cycles(200);
      check("late_req_busy_cycles", busy_cycles, 32'd160);
    end

    // Reset mid-word with a word pending, tx_ready high through release
    pulse_req(16'hBEEF, 1'b0);
    idle_cycles(5);
    pulse_req(16'hCAFE, 1'b1);
    idle_cycles(28);
    tx_ready = 1'b1;
    reset    = 1'b1;
    step();
    check("midword_reset_lines", {27'd0, tx_busy, tx_en, tx_p, tx_n, tx_ovf}, 32'd0);
    step();
    reset       = 1'b0;
    busy_cycles = 0;
    idle_cycles(100);
    check("after_reset_no_tx", busy_cycles, 32'd0);
    tx_ready = 1'b0;
    step();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 14) == 0) tx_ready = ~tx_ready;
      tx_data = 16'($urandom);
      tx_cd   = 1'($urandom);
      reset   = ($urandom_range(0, 799) == 0);
      step();
    end
    reset    = 1'b0;
    tx_ready = 1'b0;
    idle_cycles(200);
    check("final_idle", {31'd0, tx_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
